// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth digit accumulator.
// Holds the Booth code constants, the control state encoding and a
// helper that tells legal digit codes from illegal ones.
package booth_pkg;

    localparam logic [2:0] BOOTH_ZERO = 3'b000;
    localparam logic [2:0] BOOTH_P1   = 3'b001;
    localparam logic [2:0] BOOTH_P2   = 3'b010;
    localparam logic [2:0] BOOTH_N1   = 3'b101;
    localparam logic [2:0] BOOTH_N2   = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Only the five codes a Booth encoder can emit are legal.
    function automatic logic is_legal_code(input logic [2:0] code);
        logic legal;
        case (code)
            BOOTH_ZERO: legal = 1'b1;
            BOOTH_P1:   legal = 1'b1;
            BOOTH_P2:   legal = 1'b1;
            BOOTH_N1:   legal = 1'b1;
            BOOTH_N2:   legal = 1'b1;
            default:    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/booth_pp_select.sv
// Combinational partial-product selector.
// Maps a 3-bit Booth code and a signed multiplicand to the partial
// product 0, +M, +2M, -M or -2M, formed at WIDTH+2 bits so that -2M of
// the most negative multiplicand still fits. Illegal codes give 0.
// Ports: booth_code (in, 3), mcand (in, WIDTH), pp (out, WIDTH+2).
module booth_pp_select
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       booth_code,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH+1:0] pp
);

    logic [WIDTH+1:0] m_ext_s;
    logic [WIDTH+1:0] m2_ext_s;

    assign m_ext_s  = {{2{mcand[WIDTH-1]}}, mcand};
    assign m2_ext_s = {m_ext_s[WIDTH:0], 1'b0};

    // Select the signed multiple of the multiplicand.
    always_comb begin
        pp = '0;
        case (booth_code)
            BOOTH_ZERO: pp = '0;
            BOOTH_P1:   pp = m_ext_s;
            BOOTH_P2:   pp = m2_ext_s;
            BOOTH_N1:   pp = (~m_ext_s) + {{(WIDTH+1){1'b0}}, 1'b1};
            BOOTH_N2:   pp = (~m2_ext_s) + {{(WIDTH+1){1'b0}}, 1'b1};
            default:    pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_digit_accumulator.sv
// Sequential back end of a radix-4 Booth multiplier.
// Latches a signed multiplicand on start, then accepts NDIG Booth digit
// codes (LSB digit first) over a valid/ready handshake, adding each
// partial product shifted by two bits per digit into a 2*WIDTH-bit
// accumulator. The product is offered on a valid/ready output and held
// until taken. code_err flags any illegal digit seen in the operation.
// Ports: clk, rst_n (async active-low), start, mcand, busy,
//        code_valid/code_ready/booth_code (digit input),
//        prod_valid/prod_ready/product (result), code_err.
module booth_digit_accumulator
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    output logic                 busy,
    input  logic                 code_valid,
    output logic                 code_ready,
    input  logic [2:0]           booth_code,
    output logic                 prod_valid,
    input  logic                 prod_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 code_err
);

    localparam int NDIG  = WIDTH / 2;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 err_q, err_d;

    logic [WIDTH+1:0]     pp_s;
    logic [2*WIDTH-1:0]   pp_ext_s;
    logic [2*WIDTH-1:0]   pp_shift_s;
    logic                 accept_s;

    booth_pp_select #(.WIDTH(WIDTH)) u_pp_select (
        .booth_code (booth_code),
        .mcand      (mcand_q),
        .pp         (pp_s)
    );

    // Digit k carries weight 4^k, hence the shift by twice the index.
    assign pp_ext_s   = {{(WIDTH-2){pp_s[WIDTH+1]}}, pp_s};
    assign pp_shift_s = pp_ext_s << {idx_q, 1'b0};

    // Handshake outputs decode directly from the state register.
    assign code_ready = (state_q == ACCUM);
    assign busy       = (state_q != IDLE);
    assign prod_valid = (state_q == DONE);
    assign product    = acc_q;
    assign code_err   = err_q;
    assign accept_s   = code_valid && (state_q == ACCUM);

    // Next-state, datapath and sticky-error update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = mcand;
                    acc_d   = '0;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s) begin
                    // Illegal codes already select pp=0; only the flag is extra.
                    acc_d = acc_q + pp_shift_s;
                    err_d = err_q | ~is_legal_code(booth_code);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            DONE: begin
                if (prod_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_booth_digit_accumulator.sv
// Directed self-checking bench for booth_digit_accumulator (WIDTH=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_booth_digit_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  mcand;
    logic        busy;
    logic        code_valid;
    logic        code_ready;
    logic [2:0]  booth_code;
    logic        prod_valid;
    logic        prod_ready;
    logic [15:0] product;
    logic        code_err;

    integer checks = 0;
    integer errors = 0;

    booth_digit_accumulator #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mcand      (mcand),
        .busy       (busy),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .booth_code (booth_code),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .product    (product),
        .code_err   (code_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  mcand;
        logic [11:0] codes;    // digit 0 in [2:0]
        logic [15:0] exp_prod;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one operation. gap_mask bit k inserts gaps before digit k;
    // start_in_gap pulses start during those gaps; hold = cycles with prod_ready=0.
    task automatic run_op(input string name, input logic [7:0] m, input logic [11:0] codes,
                          input logic [3:0] gap_mask, input int gap_len, input bit start_in_gap,
                          input int hold, input logic [15:0] exp_prod, input logic exp_err);
        int cyc;
        logic [15:0] held;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        mcand = m;
        @(negedge clk);
        cyc = cyc + 1;
        start = 1'b0;
        mcand = 8'h00;
        check({name, " busy_accum"}, {31'd0, busy}, 32'd1);
        check({name, " err_cleared"}, {31'd0, code_err}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (gap_mask[k]) begin
                for (int g = 0; g < gap_len; g++) begin
                    code_valid = 1'b0;
                    booth_code = 3'b110;
                    start = start_in_gap;
                    mcand = 8'h55;
                    @(negedge clk);
                    cyc = cyc + 1;
                    start = 1'b0;
                    check({name, " ready_in_gap"}, {31'd0, code_ready}, 32'd1);
                end
            end
            code_valid = 1'b1;
            booth_code = codes[3*k +: 3];
            @(negedge clk);
            cyc = cyc + 1;
            code_valid = 1'b0;
        end
        check({name, " prod_valid"}, {31'd0, prod_valid}, 32'd1);
        if (gap_mask == 4'd0) begin
            check({name, " latency"}, cyc, 32'd5);
        end
        check({name, " product"}, {16'd0, product}, {16'd0, exp_prod});
        check({name, " code_err"}, {31'd0, code_err}, {31'd0, exp_err});
        held = product;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, " hold_valid"}, {31'd0, prod_valid}, 32'd1);
            check({name, " hold_product"}, {16'd0, product}, {16'd0, held});
            check({name, " hold_ready"}, {31'd0, code_ready}, 32'd0);
        end
        prod_ready = 1'b1;
        start = 1'b1;  // start coincident with the product handshake must be ignored
        @(negedge clk);
        prod_ready = 1'b0;
        start = 1'b0;
        check({name, " valid_drop"}, {31'd0, prod_valid}, 32'd0);
        check({name, " idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mcand = 8'h00;
        code_valid = 1'b0;
        booth_code = 3'b000;
        prod_ready = 1'b0;

        vecs[0] = '{8'd3,    {3'b000, 3'b000, 3'b001, 3'b001}, 16'h000F, 1'b0};
        vecs[1] = '{8'h80,   {3'b110, 3'b000, 3'b000, 3'b000}, 16'h4000, 1'b0};
        vecs[2] = '{8'hFF,   {3'b110, 3'b101, 3'b010, 3'b001}, 16'h0087, 1'b0};
        vecs[3] = '{8'h80,   {3'b110, 3'b110, 3'b110, 3'b110}, 16'h5500, 1'b0};
        vecs[4] = '{8'd7,    {3'b000, 3'b000, 3'b001, 3'b011}, 16'h001C, 1'b1};
        vecs[5] = '{8'd3,    {3'b001, 3'b010, 3'b111, 3'b100}, 16'h0120, 1'b1};

        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset code_ready", {31'd0, code_ready}, 32'd0);
        check("reset prod_valid", {31'd0, prod_valid}, 32'd0);
        check("reset product", {16'd0, product}, 32'd0);
        check("reset code_err", {31'd0, code_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].mcand, vecs[i].codes, 4'd0, 0, 1'b0, 0,
                   vecs[i].exp_prod, vecs[i].exp_err);
        end

        // Held product with prod_ready low.
        run_op("hold", 8'd127, {3'b000, 3'b000, 3'b000, 3'b101}, 4'd0, 0, 1'b0, 3, 16'hFF81, 1'b0);
        // Gaps in code_valid plus start pulses in ACCUM.
        run_op("gaps", 8'd5, {3'b000, 3'b000, 3'b001, 3'b010}, 4'b0010, 2, 1'b1, 0, 16'h001E, 1'b0);
        run_op("gaps2", 8'd5, {3'b000, 3'b000, 3'b001, 3'b010}, 4'b1000, 1, 1'b1, 0, 16'h001E, 1'b0);
        // Error flag, then cleared by the next operation.
        run_op("err", 8'd7, {3'b000, 3'b000, 3'b001, 3'b011}, 4'd0, 0, 1'b0, 0, 16'h001C, 1'b1);
        check("err sticky idle", {31'd0, code_err}, 32'd1);
        run_op("errclr", 8'd1, {3'b000, 3'b000, 3'b000, 3'b001}, 4'd0, 0, 1'b0, 0, 16'h0001, 1'b0);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1;
        mcand = 8'd9;
        @(negedge clk);
        start = 1'b0;
        code_valid = 1'b1;
        booth_code = 3'b001;
        @(negedge clk);
        booth_code = 3'b010;
        @(negedge clk);
        code_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst code_ready", {31'd0, code_ready}, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst prod_valid", {31'd0, prod_valid}, 32'd0);
        check("midrst product", {16'd0, product}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 8'd2, {3'b000, 3'b000, 3'b000, 3'b001}, 4'd0, 0, 1'b0, 0, 16'h0002, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
